// File: rtl/input_mapper_if.sv
// ============================================================================
//  Module      : input_mapper_if
//  Description : Streaming bundle for the FFT input mapper. Carries the serial
//                sample handshake (in_*) and the parallel frame handshake
//                (out_*, eight complex slots in bit-reversed DIT order).
//                slave  : the mapper (accepts samples, presents frames)
//                master : the environment (producer + FFT core)
//  Ports       : in_vld/in_rdy/in_r/in_i   serial sample channel
//                out_vld/out_rdy           frame channel handshake
//                out_r[k]/out_i[k]         frame slot k, k = 0..7
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface input_mapper_if #(
    parameter int WIDTH = 9
);
    logic                    in_vld;
    logic                    in_rdy;
    logic [WIDTH-1:0]        in_r;
    logic [WIDTH-1:0]        in_i;
    logic                    out_vld;
    logic                    out_rdy;
    logic [7:0][WIDTH-1:0]   out_r;
    logic [7:0][WIDTH-1:0]   out_i;

    modport slave (
        input  in_vld, in_r, in_i, out_rdy,
        output in_rdy, out_vld, out_r, out_i
    );

    modport master (
        output in_vld, in_r, in_i, out_rdy,
        input  in_rdy, out_vld, out_r, out_i
    );
endinterface

`default_nettype wire

// File: rtl/input_mapper.sv
// ============================================================================
//  Module      : input_mapper
//  Description : Serial-to-parallel front end of the 8-point DIT FFT. Samples
//                arrive one per cycle in natural order and are written into
//                the bit-reversed slot of a ping-pong buffer, so the core sees
//                all eight inputs in parallel in DIT order. One bank fills
//                while the other is held for the core.
//  Ports       : clk    rising-edge clock
//                rst    asynchronous active-high reset
//                flush  synchronous abort of the partially filled write bank
//                bus    input_mapper_if.slave (sample and frame channels)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module input_mapper #(
    parameter int WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input_mapper_if.slave        bus
);

    localparam logic [2:0] c_LAST_SLOT = 3'd7;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_mem_r [2][8];
    logic [WIDTH-1:0] r_mem_i [2][8];
    logic [2:0]       r_wr_cnt;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [1:0]       r_full;

    logic             w_in_rdy;
    logic             w_accept;
    logic             w_frame_done;
    logic             w_consume;
    logic [2:0]       w_slot;
    logic [1:0]       w_full_nxt;

    function automatic logic [2:0] f_bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    assign w_in_rdy     = ~r_full[r_wr_bank];
    // flush wins over a coincident sample: the sample is simply not taken
    assign w_accept     = bus.in_vld & w_in_rdy & ~flush;
    assign w_frame_done = w_accept & (r_wr_cnt == c_LAST_SLOT);
    assign w_consume    = r_full[r_rd_bank] & bus.out_rdy;
    assign w_slot       = f_bitrev3(r_wr_cnt);

    // A completing write bank is never full and a consumed read bank always
    // is, so the two updates always target different bits.
    always_comb begin
        w_full_nxt = r_full;
        if (w_consume) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_frame_done) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt  <= 3'd0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_full    <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
            if (flush) begin
                r_wr_cnt <= 3'd0;
            end else if (w_accept) begin
                r_wr_cnt <= r_wr_cnt + 3'd1;
            end
            if (w_frame_done) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_consume) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sample storage; only reset ever clears it
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 8; k++) begin
                    r_mem_r[b][k] <= '0;
                    r_mem_i[b][k] <= '0;
                end
            end
        end else if (w_accept) begin
            r_mem_r[r_wr_bank][w_slot] <= bus.in_r;
            r_mem_i[r_wr_bank][w_slot] <= bus.in_i;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: read bank presented directly from storage
    // ------------------------------------------------------------------------
    assign bus.in_rdy  = w_in_rdy;
    assign bus.out_vld = r_full[r_rd_bank];

    for (genvar k = 0; k < 8; k++) begin : g_out
        assign bus.out_r[k] = r_mem_r[r_rd_bank][k];
        assign bus.out_i[k] = r_mem_i[r_rd_bank][k];
    end

endmodule

`default_nettype wire
